// File: rtl/mul_sched_if.sv
// ============================================================================
// Module      : mul_sched_if
// Description : Requester, response and multiplier-side bundle for mul_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_sched_if #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_sign;
    logic [N_REQ*DATA_W-1:0] req_op_a;
    logic [N_REQ*DATA_W-1:0] req_op_b;
    logic [N_REQ-1:0]        resp_valid;
    logic [N_REQ-1:0]        resp_ready;
    logic [2*DATA_W-1:0]     resp_product;
    logic                    busy;
    logic                    mul_en;
    logic                    mul_sign;
    logic [DATA_W-1:0]       mul_op_a;
    logic [DATA_W-1:0]       mul_op_b;
    logic                    mul_done;
    logic [2*DATA_W-1:0]     mul_product;

    modport slave (
        input  req_valid, req_sign, req_op_a, req_op_b, resp_ready, mul_done, mul_product,
        output req_ready, resp_valid, resp_product, busy, mul_en, mul_sign, mul_op_a, mul_op_b
    );

    modport master (
        output req_valid, req_sign, req_op_a, req_op_b, resp_ready, mul_done, mul_product,
        input  req_ready, resp_valid, resp_product, busy, mul_en, mul_sign, mul_op_a, mul_op_b
    );
endinterface

`default_nettype wire

// File: rtl/mul_sched.sv
// ============================================================================
// Module      : mul_sched
// Description : Round-robin scheduler sharing one add-shift multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sched #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mul_sched_if.slave  bus
);
    localparam int c_ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_ID_W-1:0]   w_rr_nxt;
    logic                w_found;
    logic                w_accept;
    int                  w_idx;
    logic                r_sign;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [2*DATA_W-1:0] r_product;

    // Search starts at the round-robin pointer and wraps past the last requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ID_W-1:0];
            end
        end
    end

    assign w_rr_nxt = (w_winner == c_ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_accept = (r_state == S_IDLE) && w_found;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found)             w_state_nxt = S_RUN;
            S_RUN:   if (bus.mul_done)        w_state_nxt = S_RESP;
            S_RESP:  if (bus.resp_ready[r_id]) w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_sign    <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a   <= bus.req_op_a[w_winner*DATA_W +: DATA_W];
                r_op_b   <= bus.req_op_b[w_winner*DATA_W +: DATA_W];
                r_sign   <= bus.req_sign[w_winner];
                r_id     <= w_winner;
                r_rr_ptr <= w_rr_nxt;
            end
            // done is only trusted while the multiplier is enabled
            if ((r_state == S_RUN) && bus.mul_done) begin
                r_product <= bus.mul_product;
            end
        end
    end

    // Grant is gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (w_accept && rst_n) begin
            bus.req_ready[w_winner] = 1'b1;
        end
        bus.resp_valid = '0;
        if (r_state == S_RESP) begin
            bus.resp_valid[r_id] = 1'b1;
        end
    end

    assign bus.resp_product = r_product;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.mul_en       = (r_state == S_RUN);
    assign bus.mul_sign     = r_sign;
    assign bus.mul_op_a     = r_op_a;
    assign bus.mul_op_b     = r_op_b;

endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// ============================================================================
// Module      : tb_mul_sched
// Description : Scoreboard bench for mul_sched with a behavioural multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sched;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int LAT = DW + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_sched_if #(.DATA_W(DW), .N_REQ(NR)) bus();

    mul_sched #(.DATA_W(DW), .N_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        logic [63:0] ua, ub;
        if (s) begin
            sa  = longint'($signed(a));
            sb2 = longint'($signed(b));
            return 64'(sa * sb2);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Behavioural multiplier: done after DW+1 enabled edges, cleared when en drops,
    // done powers up high and product is garbage until done.
    int   mcnt  = 0;
    logic mdone = 1'b1;
    always @(posedge clk) begin
        if (!bus.mul_en) begin
            mcnt  <= 0;
            mdone <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == DW) mdone <= 1'b1;
        end
    end
    assign bus.mul_done    = mdone;
    assign bus.mul_product = mdone ? ref_mul(bus.mul_sign, bus.mul_op_a, bus.mul_op_b)
                                   : 64'hA5A5_5A5A_DEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          grants[$];
    int          mptr = 0;
    int          mw;
    int          ga;
    logic        prev_rv = 1'b0;
    logic [63:0] held;
    logic [63:0] last_prod;

    // Monitor: reference round-robin grant, scoreboard push on accept, pop on response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mptr    = 0;
            prev_rv = 1'b0;
        end else begin
            chk("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
            chk("resp_valid_onehot0", 64'($onehot0(bus.resp_valid)), 64'd1);
            if (bus.req_ready != 0) begin
                chk("ready_while_busy", 64'(bus.busy), 64'd0);
                mw = -1;
                for (int k = 0; k < NR; k++)
                    if (mw < 0 && bus.req_valid[(mptr + k) % NR]) mw = (mptr + k) % NR;
                chk("rr_grant", 64'(bus.req_ready), (mw < 0) ? 64'd0 : 64'(1 << mw));
                ga = 0;
                for (int k = 0; k < NR; k++) if (bus.req_ready[k]) ga = k;
                sb.push_back('{ga, ref_mul(bus.req_sign[ga], bus.req_op_a[ga*DW +: DW],
                                           bus.req_op_b[ga*DW +: DW]), cyc});
                grants.push_back(ga);
                mptr = (ga + 1) % NR;
            end
            if (bus.resp_valid != 0) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
                end else if (!prev_rv) begin
                    chk("resp_id", 64'(bus.resp_valid), 64'(1 << sb[0].id));
                    chk("resp_product", bus.resp_product, sb[0].prod);
                    chk("resp_latency", 64'(cyc - sb[0].t), 64'(LAT));
                    held      = bus.resp_product;
                    last_prod = bus.resp_product;
                end else begin
                    chk("resp_stable", bus.resp_product, held);
                end
                prev_rv = 1'b1;
                if (sb.size() > 0 && bus.resp_ready[sb[0].id]) begin
                    void'(sb.pop_front());
                    prev_rv = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.req_sign[i]          = s;
        bus.req_op_a[i*DW +: DW] = a;
        bus.req_op_b[i*DW +: DW] = b;
        bus.req_valid[i]         = 1'b1;
    endtask

    // Drops each valid after its accept and waits for all outstanding jobs to finish.
    task automatic run(input string name, input int lim, input bit rand_bp);
        int n;
        logic [NR-1:0] acc;
        n = 0;
        while ((bus.req_valid != 0 || sb.size() != 0 || bus.busy) && n < lim) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~acc;
            if (rand_bp) bus.resp_ready = NR'($urandom);
            n++;
        end
        total++;
        if (n >= lim) begin
            bad++;
            $display("FAIL %s_timeout: waited %0d cycles, limit %0d", name, n, lim);
        end
        bus.resp_ready = '1;
    endtask

    task automatic wait_ready(input int i, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s_ready_timeout: req_ready[%0d]=0 expected 1", name, i);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_req_ready"},  64'(bus.req_ready), 64'd0);
        chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({name, "_resp_prod"},  bus.resp_product, 64'd0);
        chk({name, "_busy"},       64'(bus.busy), 64'd0);
        chk({name, "_mul_en"},     64'(bus.mul_en), 64'd0);
        chk({name, "_mul_sign"},   64'(bus.mul_sign), 64'd0);
        chk({name, "_mul_op_a"},   64'(bus.mul_op_a), 64'd0);
        chk({name, "_mul_op_b"},   64'(bus.mul_op_b), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] p0;
        bus.req_valid  = '0;
        bus.req_sign   = '0;
        bus.req_op_a   = '0;
        bus.req_op_b   = '0;
        bus.resp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Unsigned corner
        set_req(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("t1", 100, 1'b0);
        chk("t1_product", last_prod, 64'hFFFF_FFFE_0000_0001);

        // Signed cases
        set_req(1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        run("t2a", 100, 1'b0);
        chk("t2a_product", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
        set_req(1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        run("t2b", 100, 1'b0);
        chk("t2b_product", last_prod, 64'h4000_0000_0000_0000);

        // All requesters valid out of reset
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'($urandom), $urandom, $urandom);
        repeat (2) @(posedge clk);
        #1;
        grants.delete();
        rst_n = 1'b1;
        run("t3a", 400, 1'b0);
        chk("t3a_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < NR && i < grants.size(); i++) chk("t3a_order", 64'(grants[i]), 64'(i));
        grants.delete();
        set_req(2, 1'b0, $urandom, $urandom);
        set_req(0, 1'b1, $urandom, $urandom);
        run("t3b", 200, 1'b0);
        chk("t3b_count", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            chk("t3b_first", 64'(grants[0]), 64'd0);
            chk("t3b_second", 64'(grants[1]), 64'd2);
        end

        // Backpressure on requester 0 while requester 3 waits
        bus.resp_ready[0] = 1'b0;
        set_req(0, 1'b0, $urandom, $urandom);
        wait_ready(0, "t4");
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        set_req(3, 1'b1, $urandom, $urandom);
        n = 0;
        while (!bus.resp_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_resp_seen", 64'(bus.resp_valid), 64'b0001);
        p0 = bus.resp_product;
        repeat (10) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(bus.resp_valid), 64'b0001);
            chk("t4_hold_prod", bus.resp_product, p0);
            chk("t4_no_grant3", 64'(bus.req_ready[3]), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_grant3_next", 64'(bus.req_ready), 64'b1000);
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        run("t4", 100, 1'b0);

        // Reset in the middle of a job
        set_req(1, 1'b0, $urandom, $urandom);
        wait_ready(1, "t5");
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check_zero("t5_midrun");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(0, 1'b0, 32'd5, 32'd6);
        run("t5", 100, 1'b0);
        chk("t5_product", last_prod, 64'd30);

        // Operands of a waiting requester change before and after acceptance
        set_req(0, 1'b0, $urandom, $urandom);
        wait_ready(0, "t6a");
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        set_req(2, 1'b0, 32'd111, 32'd222);
        repeat (5) @(posedge clk);
        #1;
        set_req(2, 1'b1, 32'h0001_0000, 32'h0000_0100);
        wait_ready(2, "t6");
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        bus.req_sign[2]  = 1'b0;
        bus.req_op_a[2*DW +: DW] = 32'hDEAD_BEEF;
        bus.req_op_b[2*DW +: DW] = 32'hCAFE_F00D;
        run("t6", 200, 1'b0);
        chk("t6_product", last_prod, 64'h0000_0000_0100_0000);

        // Random traffic with random response backpressure
        for (int it = 0; it < 40; it++) begin
            logic [NR-1:0] m;
            m = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++)
                if (m[i]) set_req(i, 1'($urandom), $urandom, $urandom);
            run("rand", 1500, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

`default_nettype wire
